fix_msg_serializer: RTL and testbench

Transmit-side counterpart to the FIX tag parser. Pops binary tag numbers from a tag FIFO and ASCII value bytes from a value FIFO, both `fifo_top` instances, and emits a FIX byte stream of the form `tag=value<SOH>`. A running checksum is kept, and the block appends the `10=NNN<SOH>` trailer when an end-of-message marker is popped. It sits between the outbound field FIFOs and the byte-serial line/MAC interface.

---
 rtl/fix_msg_serializer_if.sv | 30 +++
 rtl/fix_msg_serializer.sv | 191 +++++++++++++++++++
 tb/tb_fix_msg_serializer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fix_msg_serializer_if.sv
// Field-FIFO read ports and byte-serial output of the FIX serializer.
interface fix_msg_serializer_if #(
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
);
  logic [TAG_W-1:0] tag_data_i;
  logic             tag_empty_i;
  logic             tag_rd_en_o;
  logic [8:0]       val_data_i;
  logic             val_empty_i;
  logic             val_rd_en_o;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_ready_i;
  logic             byte_last_o;
  logic             busy_o;
  logic [CNT_W-1:0] msg_cnt_o;

  modport master (
    input  tag_data_i, tag_empty_i, val_data_i, val_empty_i, byte_ready_i,
    output tag_rd_en_o, val_rd_en_o, byte_o, byte_valid_o, byte_last_o,
           busy_o, msg_cnt_o
  );

  modport slave (
    output tag_data_i, tag_empty_i, val_data_i, val_empty_i, byte_ready_i,
    input  tag_rd_en_o, val_rd_en_o, byte_o, byte_valid_o, byte_last_o,
           busy_o, msg_cnt_o
  );
endinterface

// File: rtl/fix_msg_serializer.sv
// Turns binary tags + ASCII value bytes into "tag=value<SOH>" fields and a "10=NNN<SOH>" trailer.
// Output byte is registered and only advances on valid&&ready, so backpressure never reaches the FIFOs mid-byte.
module fix_msg_serializer #(
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fix_msg_serializer_if.master  bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TAG_RD   = 4'd1;
  localparam logic [3:0] S_TAG_WAIT = 4'd2;
  localparam logic [3:0] S_CONV     = 4'd3;
  localparam logic [3:0] S_DIGIT    = 4'd4;
  localparam logic [3:0] S_EQ       = 4'd5;
  localparam logic [3:0] S_VAL_RD   = 4'd6;
  localparam logic [3:0] S_VAL_WAIT = 4'd7;
  localparam logic [3:0] S_VAL_OUT  = 4'd8;
  localparam logic [3:0] S_SOH      = 4'd9;
  localparam logic [3:0] S_CK_HDR   = 4'd10;
  localparam logic [3:0] S_CK_DIG   = 4'd11;
  localparam logic [3:0] S_CK_SOH   = 4'd12;

  logic [3:0]       state;
  logic [16:0]      bin_sr;
  logic [23:0]      bcd;
  logic [4:0]       step_cnt;
  logic [2:0]       dig_idx;
  logic [1:0]       ck_idx;
  logic             val_last;
  logic [7:0]       cks;
  logic [7:0]       byte_q;
  logic             vld_q;
  logic             last_q;
  logic [CNT_W-1:0] msg_cnt;

  logic [23:0]      bcd_nxt;
  logic [2:0]       msd_nxt;
  logic [7:0]       ck_d0, ck_d1, ck_d2;
  logic             xfer;
  logic             unused_tag_bits;

  function automatic logic [23:0] dd_step(input logic [23:0] b, input logic in_bit);
    logic [23:0] t;
    t = b;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[22:0], in_bit};
  endfunction

  // Index of the most significant non-zero digit; 0 for an all-zero value so tag 0 prints "0".
  function automatic logic [2:0] msd(input logic [23:0] b);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (b[i*4 +: 4] != 4'd0) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_chr(input logic [23:0] b, input logic [2:0] idx);
    return 8'h30 + {4'h0, b[{idx, 2'b00} +: 4]};
  endfunction

  assign bcd_nxt = dd_step(bcd, bin_sr[16]);
  assign msd_nxt = msd(bcd_nxt);
  assign ck_d0   = 8'h30 + cks / 8'd100;
  assign ck_d1   = 8'h30 + (cks / 8'd10) % 8'd10;
  assign ck_d2   = 8'h30 + cks % 8'd10;
  assign xfer    = vld_q && bus.byte_ready_i;

  assign unused_tag_bits = ^bus.tag_data_i[30:17];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bin_sr   <= '0;
      bcd      <= '0;
      step_cnt <= '0;
      dig_idx  <= '0;
      ck_idx   <= '0;
      val_last <= 1'b0;
      cks      <= '0;
      byte_q   <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      msg_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (!bus.tag_empty_i) state <= S_TAG_RD;
        S_TAG_RD: state <= S_TAG_WAIT;
        S_TAG_WAIT: begin
          if (bus.tag_data_i[31]) begin
            byte_q <= 8'h31;
            vld_q  <= 1'b1;
            ck_idx <= 2'd0;
            state  <= S_CK_HDR;
          end else begin
            bin_sr   <= bus.tag_data_i[16:0];
            bcd      <= '0;
            step_cnt <= '0;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          bcd      <= bcd_nxt;
          bin_sr   <= {bin_sr[15:0], 1'b0};
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == 5'd16) begin
            byte_q  <= bcd_chr(bcd_nxt, msd_nxt);
            dig_idx <= msd_nxt;
            vld_q   <= 1'b1;
            state   <= S_DIGIT;
          end
        end
        S_DIGIT: if (xfer) begin
          cks <= cks + byte_q;
          if (dig_idx == 3'd0) begin
            byte_q <= 8'h3D;
            state  <= S_EQ;
          end else begin
            dig_idx <= dig_idx - 3'd1;
            byte_q  <= bcd_chr(bcd, dig_idx - 3'd1);
          end
        end
        S_EQ: if (xfer) begin
          cks   <= cks + byte_q;
          vld_q <= 1'b0;
          state <= S_VAL_RD;
        end
        S_VAL_RD: if (!bus.val_empty_i) state <= S_VAL_WAIT;
        S_VAL_WAIT: begin
          byte_q   <= bus.val_data_i[7:0];
          val_last <= bus.val_data_i[8];
          vld_q    <= 1'b1;
          state    <= S_VAL_OUT;
        end
        S_VAL_OUT: if (xfer) begin
          cks <= cks + byte_q;
          if (val_last) begin
            byte_q <= 8'h01;
            state  <= S_SOH;
          end else begin
            vld_q <= 1'b0;
            state <= S_VAL_RD;
          end
        end
        S_SOH: if (xfer) begin
          cks   <= cks + byte_q;
          vld_q <= 1'b0;
          state <= S_IDLE;
        end
        // Trailer bytes are never folded into the checksum, so cks is frozen from here on.
        S_CK_HDR: if (xfer) begin
          case (ck_idx)
            2'd0:    begin byte_q <= 8'h30; ck_idx <= 2'd1; end
            2'd1:    begin byte_q <= 8'h3D; ck_idx <= 2'd2; end
            default: begin byte_q <= ck_d0; ck_idx <= 2'd0; state <= S_CK_DIG; end
          endcase
        end
        S_CK_DIG: if (xfer) begin
          case (ck_idx)
            2'd0:    begin byte_q <= ck_d1; ck_idx <= 2'd1; end
            2'd1:    begin byte_q <= ck_d2; ck_idx <= 2'd2; end
            default: begin byte_q <= 8'h01; last_q <= 1'b1; state <= S_CK_SOH; end
          endcase
        end
        S_CK_SOH: if (xfer) begin
          vld_q   <= 1'b0;
          last_q  <= 1'b0;
          msg_cnt <= msg_cnt + 1'b1;
          cks     <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tag_rd_en_o  = (state == S_TAG_RD);
  assign bus.val_rd_en_o  = (state == S_VAL_RD) && !bus.val_empty_i;
  assign bus.byte_o       = byte_q;
  assign bus.byte_valid_o = vld_q;
  assign bus.byte_last_o  = last_q;
  assign bus.busy_o       = (state != S_IDLE);
  assign bus.msg_cnt_o    = msg_cnt;

endmodule

// File: tb/tb_fix_msg_serializer.sv
// Directed + random messages through behavioural field FIFOs; the byte stream is compared against a string-level FIX model.
module tb_fix_msg_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  fix_msg_serializer_if #(.TAG_W(32), .CNT_W(16)) bus ();
  fix_msg_serializer #(.TAG_W(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  // FIFO models: registered data, valid the cycle after rd_en; reset flushes them.
  logic [31:0] tag_mem[$];
  logic [8:0]  val_mem[$];
  int          tag_wr_n = 0, tag_rd_n = 0, val_wr_n = 0, val_rd_n = 0;
  logic [31:0] tag_dat = '0;
  logic [8:0]  val_dat = '0;
  logic        val_hold = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      tag_rd_n <= tag_wr_n;
      val_rd_n <= val_wr_n;
    end else begin
      if (bus.tag_rd_en_o && tag_rd_n != tag_wr_n) begin
        tag_dat  <= tag_mem[tag_rd_n];
        tag_rd_n <= tag_rd_n + 1;
      end
      if (bus.val_rd_en_o && val_rd_n != val_wr_n) begin
        val_dat  <= val_mem[val_rd_n];
        val_rd_n <= val_rd_n + 1;
      end
    end
  end

  assign bus.tag_data_i   = tag_dat;
  assign bus.tag_empty_i  = (tag_wr_n == tag_rd_n);
  assign bus.val_data_i   = val_dat;
  assign bus.val_empty_i  = (val_wr_n == val_rd_n) || val_hold;
  assign bus.byte_ready_i = rdy;

  int tests = 0, fails = 0;
  logic [8:0]  rx_q[$];
  int          rx_rd = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] f_word[$];
  string       f_val[$];
  int          exp_msgs = 0;
  logic        rdy_rand = 1'b0;
  logic        bp_arm = 1'b0;
  int          bp_cnt = 0;
  logic        p_vld = 1'b0, p_rdy = 1'b1, p_rst = 1'b1;
  logic [8:0]  p_dat = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One cycle: drive ready, watch the handshake rules, and record bytes that will transfer on the next edge.
  task automatic step();
    logic nr;
    @(negedge clk);
    if (bp_arm && bus.byte_valid_o && bus.byte_o == 8'h3D) begin
      bp_arm = 1'b0;
      bp_cnt = 5;
    end
    if (bp_cnt > 0) begin
      check("bp_valid", 32'(bus.byte_valid_o), 32'd1);
      check("bp_byte", 32'(bus.byte_o), 32'h3D);
      check("bp_no_read", 32'({bus.tag_rd_en_o, bus.val_rd_en_o}), 32'd0);
      bp_cnt--;
      nr = 1'b0;
    end else if (rdy_rand) nr = ($urandom_range(0, 3) != 0);
    else nr = 1'b1;
    if (p_vld && !p_rdy && !p_rst) begin
      check("hold_valid", 32'(bus.byte_valid_o), 32'd1);
      check("hold_data", 32'({bus.byte_last_o, bus.byte_o}), 32'(p_dat));
    end
    if (bus.tag_rd_en_o) check("tag_rd_when_empty", 32'(bus.tag_empty_i), 32'd0);
    if (bus.val_rd_en_o) check("val_rd_when_empty", 32'(bus.val_empty_i), 32'd0);
    rdy = nr;
    if (bus.byte_valid_o && nr && !rst) rx_q.push_back({bus.byte_last_o, bus.byte_o});
    p_vld = bus.byte_valid_o;
    p_rdy = nr;
    p_dat = {bus.byte_last_o, bus.byte_o};
    p_rst = rst;
  endtask

  task automatic add_field(input logic [31:0] word, input string v);
    f_word.push_back(word);
    f_val.push_back(v);
  endtask

  // Reference model: build the expected text directly from the FIX field rules.
  task automatic send_msg();
    logic [7:0] sum;
    string s;
    sum = 8'd0;
    exp_q.delete();
    foreach (f_word[k]) begin
      s = $sformatf("%0d=%s", f_word[k][16:0], f_val[k]);
      for (int i = 0; i < s.len(); i++) begin
        exp_q.push_back(8'(s[i]));
        sum = sum + 8'(s[i]);
      end
      exp_q.push_back(8'h01);
      sum = sum + 8'h01;
      tag_mem.push_back(f_word[k]);
      tag_wr_n++;
      for (int i = 0; i < f_val[k].len(); i++) begin
        val_mem.push_back({(i == f_val[k].len() - 1), 8'(f_val[k][i])});
        val_wr_n++;
      end
    end
    s = $sformatf("10=%03d", sum);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h01);
    tag_mem.push_back(32'h8000_0000);
    tag_wr_n++;
    exp_msgs++;
    f_word.delete();
    f_val.delete();
  endtask

  task automatic run_check(input string name);
    int n, got_n;
    n = 0;
    while (((rx_q.size() - rx_rd) < exp_q.size() || bus.busy_o) && n < 4000) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 4000), 32'd1);
    repeat (3) step();
    got_n = rx_q.size() - rx_rd;
    check({name, "_len"}, 32'(got_n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      check($sformatf("%s_byte%0d", name, i), 32'(rx_q[rx_rd + i][7:0]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", name, i), 32'(rx_q[rx_rd + i][8]), 32'(i == exp_q.size() - 1));
    end
    rx_rd = rx_q.size();
    check({name, "_msg_cnt"}, 32'(bus.msg_cnt_o), 32'(exp_msgs));
  endtask

  task automatic rand_value(output string v);
    int len;
    v = "";
    len = $urandom_range(1, 5);
    for (int i = 0; i < len; i++) v = {v, string'(8'($urandom_range(33, 126)))};
  endtask

  initial begin
    int n;
    string v;
    int nf;

    rst = 1'b1;
    repeat (2) step();
    check("rst_byte", 32'(bus.byte_o), 32'd0);
    check("rst_valid", 32'(bus.byte_valid_o), 32'd0);
    check("rst_last", 32'(bus.byte_last_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_msg_cnt", 32'(bus.msg_cnt_o), 32'd0);
    rst = 1'b0;
    step();

    // Single field, with first-digit latency measured from the tag read.
    add_field(32'd35, "D");
    send_msg();
    n = 0;
    while (!bus.tag_rd_en_o && n < 50) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (!bus.byte_valid_o && n < 50);
    check("tag_latency", 32'(n), 32'd19);
    run_check("single");

    add_field(32'd8, "FIX.4.2");
    send_msg();
    run_check("cks_wrap");

    add_field(32'd0, "a");
    add_field({1'b0, 14'h3FFF, 17'h1FFFF}, "b");
    send_msg();
    run_check("tag_edges");

    bp_arm = 1'b1;
    add_field(32'd49, "x");
    send_msg();
    run_check("backpressure");
    check("bp_consumed", 32'(bp_arm), 32'd0);

    send_msg();
    run_check("bare_eom");

    // Value FIFO runs dry right after the first value byte.
    add_field(32'd77, "STALL");
    send_msg();
    n = 0;
    do begin step(); n++; end while (!(bus.byte_valid_o && bus.byte_o == 8'h53) && n < 200);
    val_hold = 1'b1;
    repeat (10) begin
      step();
      check("stall_no_valid", 32'(bus.byte_valid_o), 32'd0);
      check("stall_no_read", 32'(bus.val_rd_en_o), 32'd0);
    end
    val_hold = 1'b0;
    run_check("stall");

    rdy_rand = 1'b1;
    for (int m = 0; m < 8; m++) begin
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        rand_value(v);
        add_field({1'b0, 14'($urandom_range(0, 16383)), 17'($urandom_range(0, 131071))}, v);
      end
      send_msg();
      run_check($sformatf("rand%0d", m));
    end
    rdy_rand = 1'b0;

    // Abort during a value byte, then a clean message must carry its own checksum.
    add_field(32'd12, "QRSTU");
    send_msg();
    n = 0;
    do begin step(); n++; end while (!(bus.byte_valid_o && bus.byte_o == 8'h51) && n < 200);
    rst = 1'b1;
    step();
    check("mid_rst_byte", 32'(bus.byte_o), 32'd0);
    check("mid_rst_valid", 32'(bus.byte_valid_o), 32'd0);
    check("mid_rst_last", 32'(bus.byte_last_o), 32'd0);
    check("mid_rst_rd", 32'({bus.tag_rd_en_o, bus.val_rd_en_o}), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_msg_cnt", 32'(bus.msg_cnt_o), 32'd0);
    rst = 1'b0;
    rx_rd = rx_q.size();
    exp_msgs = 0;
    step();
    add_field(32'd35, "D");
    send_msg();
    run_check("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
